// File: rtl/layer_serializer_if.sv
// Stream bundle between a neuron layer and its consumer.
// master = serializer side, slave = producer/consumer environment side.
interface layer_serializer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int NEURONS_NUM = 10,
    parameter int LANES       = 1,
    parameter int IDX_W       = (NEURONS_NUM > 1) ? $clog2(NEURONS_NUM) : 1
);
    logic                            i_flush;
    logic                            i_data_in_valid;
    logic [NEURONS_NUM*DATA_WIDTH-1:0] i_data_in;
    logic [LANES*DATA_WIDTH-1:0]     o_data;
    logic                            o_valid;
    logic                            i_ready;
    logic                            o_last;
    logic [IDX_W-1:0]                o_index;
    logic                            o_busy;
    logic                            o_overflow;
    logic                            i_clear_overflow;

    modport master (
        input  i_flush, i_data_in_valid, i_data_in, i_ready, i_clear_overflow,
        output o_data, o_valid, o_last, o_index, o_busy, o_overflow
    );

    modport slave (
        output i_flush, i_data_in_valid, i_data_in, i_ready, i_clear_overflow,
        input  o_data, o_valid, o_last, o_index, o_busy, o_overflow
    );
endinterface

// File: rtl/layer_serializer.sv
// Captures a NEURONS_NUM-word layer vector and replays it as a LANES-wide valid/ready stream.
// Define SERIALIZER_DOUBLE_BUFFER_EN to add a shadow vector that absorbs one capture while sending.
module layer_serializer #(
    parameter int DATA_WIDTH  = 16,
    parameter int NEURONS_NUM = 10,
    parameter int LANES       = 1,
    parameter int IDX_W       = (NEURONS_NUM > 1) ? $clog2(NEURONS_NUM) : 1
) (
    input logic               clk,
    input logic               reset_n,
    layer_serializer_if.master bus
);
    // state | meaning
    // IDLE  | no vector held
    // SEND  | vector held, beats outstanding
    localparam int VEC_W  = NEURONS_NUM * DATA_WIDTH;
    localparam int BEAT_W = LANES * DATA_WIDTH;
    localparam int BEATS  = NEURONS_NUM / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q;
    logic [VEC_W-1:0]   load_vec;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   rem_q;
    logic               last_q;
    logic               ovf_q;
    logic               in_send;
    logic               xfer;
    logic               last_xfer;
    logic               cap_ok;
    logic               load_active;
    logic               drop;
    logic               pending;

    assign in_send   = (state_q == SEND);
    assign xfer      = in_send && bus.i_ready;
    assign last_xfer = xfer && last_q;
    assign cap_ok    = bus.i_data_in_valid && !bus.i_flush;

`ifdef SERIALIZER_DOUBLE_BUFFER_EN
    logic [VEC_W-1:0] shadow_q;
    logic             shadow_full_q;
    logic             load_direct;
    logic             shadow_drain;
    logic             to_shadow;

    assign shadow_drain = last_xfer && shadow_full_q && !bus.i_flush;
    assign load_direct  = cap_ok && (!in_send || (last_xfer && !shadow_full_q));
    // A full shadow can take a new vector only on the cycle it moves to active.
    assign to_shadow    = cap_ok && in_send &&
                          ((!shadow_full_q && !last_xfer) || (shadow_full_q && last_xfer));
    assign drop         = cap_ok && in_send && shadow_full_q && !last_xfer;
    assign load_active  = load_direct || shadow_drain;
    assign load_vec     = shadow_drain ? shadow_q : bus.i_data_in;
    assign pending      = shadow_full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else if (bus.i_flush) begin
            shadow_full_q <= 1'b0;
        end else if (to_shadow) begin
            shadow_q      <= bus.i_data_in;
            shadow_full_q <= 1'b1;
        end else if (shadow_drain) begin
            shadow_full_q <= 1'b0;
        end
    end
`else
    assign load_active = cap_ok && (!in_send || last_xfer);
    assign drop        = cap_ok && in_send && !last_xfer;
    assign load_vec    = bus.i_data_in;
    assign pending     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (load_active) state_d = SEND;
            SEND: begin
                if (bus.i_flush)                     state_d = IDLE;
                else if (last_xfer && !load_active)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_valid    = in_send;
        bus.o_busy     = in_send || pending;
        bus.o_data     = vec_q[BEAT_W-1:0];
        bus.o_index    = idx_q;
        bus.o_last     = last_q;
        bus.o_overflow = ovf_q;
    end

    // Lane 0 of the current beat always sits in the low bits; each transfer shifts one beat out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_q  <= '0;
            idx_q  <= '0;
            rem_q  <= '0;
            last_q <= 1'b0;
        end else if (bus.i_flush) begin
            last_q <= 1'b0;
        end else if (load_active) begin
            vec_q  <= load_vec;
            idx_q  <= '0;
            rem_q  <= CNT_W'(BEATS - 1);
            last_q <= (BEATS == 1);
        end else if (xfer) begin
            vec_q  <= vec_q >> BEAT_W;
            idx_q  <= idx_q + IDX_W'(LANES);
            if (rem_q != '0) rem_q <= rem_q - CNT_W'(1);
            last_q <= (rem_q == CNT_W'(1));
        end
    end

    // Set beats clear when both happen together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  ovf_q <= 1'b0;
        else if (drop)                 ovf_q <= 1'b1;
        else if (bus.i_clear_overflow) ovf_q <= 1'b0;
    end
endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: LANES=1 and LANES=2 instances share one stimulus stream,
// each checked against a vector/position reference model.
`timescale 1ns/1ps
module tb_layer_serializer;
    localparam int DW = 16;
    localparam int N  = 10;
    localparam int VW = N * DW;
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          flush   = 1'b0;
    logic          cap     = 1'b0;
    logic          rdy     = 1'b0;
    logic          clr     = 1'b0;
    logic [VW-1:0] cap_vec = '0;

    always #5 clk = ~clk;

    layer_serializer_if #(.DATA_WIDTH(DW), .NEURONS_NUM(N), .LANES(1)) bus1 ();
    layer_serializer_if #(.DATA_WIDTH(DW), .NEURONS_NUM(N), .LANES(2)) bus2 ();

    assign bus1.i_flush          = flush;
    assign bus1.i_data_in_valid  = cap;
    assign bus1.i_data_in        = cap_vec;
    assign bus1.i_ready          = rdy;
    assign bus1.i_clear_overflow = clr;
    assign bus2.i_flush          = flush;
    assign bus2.i_data_in_valid  = cap;
    assign bus2.i_data_in        = cap_vec;
    assign bus2.i_ready          = rdy;
    assign bus2.i_clear_overflow = clr;

    layer_serializer #(.DATA_WIDTH(DW), .NEURONS_NUM(N), .LANES(1)) u_l1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));
    layer_serializer #(.DATA_WIDTH(DW), .NEURONS_NUM(N), .LANES(2)) u_l2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2));

    logic [31:0] ob_data [2];
    logic [31:0] ob_idx  [2];
    logic [31:0] ob_vld  [2];
    logic [31:0] ob_last [2];
    logic [31:0] ob_busy [2];
    logic [31:0] ob_ovf  [2];
    assign ob_data[0] = 32'(bus1.o_data);
    assign ob_data[1] = 32'(bus2.o_data);
    assign ob_idx[0]  = 32'(bus1.o_index);
    assign ob_idx[1]  = 32'(bus2.o_index);
    assign ob_vld[0]  = 32'(bus1.o_valid);
    assign ob_vld[1]  = 32'(bus2.o_valid);
    assign ob_last[0] = 32'(bus1.o_last);
    assign ob_last[1] = 32'(bus2.o_last);
    assign ob_busy[0] = 32'(bus1.o_busy);
    assign ob_busy[1] = 32'(bus2.o_busy);
    assign ob_ovf[0]  = 32'(bus1.o_overflow);
    assign ob_ovf[1]  = 32'(bus2.o_overflow);

    // Model: active vector plus count of words still to send, optional shadow, overflow flag.
    logic [VW-1:0] m_vec [2];
    logic [VW-1:0] m_sh  [2];
    int            m_pos [2];
    bit            m_shv [2];
    bit            m_ovf [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s lanes=%0d observed=%0h expected=%0h", tag, inst + 1, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_vec[i] = '0; m_sh[i] = '0; m_pos[i] = 0; m_shv[i] = 1'b0; m_ovf[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        int L;
        bit valid, xfer, lastx, drop;
        L     = i + 1;
        valid = (m_pos[i] > 0);
        xfer  = valid && rdy;
        lastx = xfer && (m_pos[i] == L);
        drop  = 1'b0;
        if (xfer) m_pos[i] = m_pos[i] - L;
        if (flush) begin
            m_pos[i] = 0;
            m_shv[i] = 1'b0;
        end else if (cap) begin
            if (!valid || (lastx && !m_shv[i])) begin
                m_vec[i] = cap_vec; m_pos[i] = N;
            end else if (DB && (!m_shv[i] || lastx)) begin
                if (lastx) begin m_vec[i] = m_sh[i]; m_pos[i] = N; end
                m_sh[i] = cap_vec; m_shv[i] = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (lastx && m_shv[i]) begin
            m_vec[i] = m_sh[i]; m_pos[i] = N; m_shv[i] = 1'b0;
        end
        if (drop)     m_ovf[i] = 1'b1;
        else if (clr) m_ovf[i] = 1'b0;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int            L;
            logic [VW-1:0] sh;
            logic [31:0]   mask;
            bit            ev;
            L    = i + 1;
            ev   = (m_pos[i] > 0);
            mask = (L == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            sh   = m_vec[i] >> ((N - m_pos[i]) * DW);
            chk("valid",    i, ob_vld[i],  32'(ev));
            chk("last",     i, ob_last[i], 32'(m_pos[i] == L));
            chk("busy",     i, ob_busy[i], 32'(ev || m_shv[i]));
            chk("overflow", i, ob_ovf[i],  32'(m_ovf[i]));
            if (ev) begin
                chk("data",  i, ob_data[i], sh[31:0] & mask);
                chk("index", i, ob_idx[i],  32'(N - m_pos[i]));
            end
        end
    endtask

    task automatic check_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, ob_vld[i],  32'h0);
            chk("rst_last",  i, ob_last[i], 32'h0);
            chk("rst_busy",  i, ob_busy[i], 32'h0);
            chk("rst_ovf",   i, ob_ovf[i],  32'h0);
            chk("rst_index", i, ob_idx[i],  32'h0);
            chk("rst_data",  i, ob_data[i], 32'h0);
        end
    endtask

    task automatic tick(input bit c, input bit r, input bit f, input bit cl);
        cap = c; rdy = r; flush = f; clr = cl;
        @(negedge clk);
        check_all();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        cap = 1'b0; flush = 1'b0; clr = 1'b0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        #1 check_reset();
        @(posedge clk); #1 reset_n = 1'b1;

        // basic order: words 1..10
        for (int k = 0; k < N; k++) cap_vec[k*DW +: DW] = DW'(k + 1);
        tick(1, 1, 0, 0);
        repeat (13) tick(0, 1, 0, 0);

        // backpressure 1,0,0,1
        cap_vec = rand_vec();
        tick(1, 1, 0, 0);
        for (int c = 0; c < 40; c++) tick(0, (c % 4 == 0) || (c % 4 == 3), 0, 0);
        repeat (4) tick(0, 1, 0, 0);

        // overflow: second capture at beat 3, third at beat 4, then clear
        cap_vec = rand_vec(); tick(1, 1, 0, 0);
        repeat (3) tick(0, 1, 0, 0);
        cap_vec = rand_vec(); tick(1, 1, 0, 0);
        cap_vec = rand_vec(); tick(1, 1, 0, 0);
        repeat (3) tick(0, 1, 0, 0);
        tick(0, 1, 0, 1);
        repeat (24) tick(0, 1, 0, 0);

        // back-to-back capture on the last beat of the single-lane stream
        cap_vec = rand_vec(); tick(1, 1, 0, 0);
        repeat (9) tick(0, 1, 0, 0);
        cap_vec = rand_vec(); tick(1, 1, 0, 0);
        repeat (12) tick(0, 1, 0, 0);

        // drop coinciding with clear: set wins
        cap_vec = rand_vec(); tick(1, 0, 0, 0);
        cap_vec = rand_vec(); tick(1, 0, 0, 0);
        cap_vec = rand_vec(); tick(1, 0, 0, 1);
        repeat (24) tick(0, 1, 0, 0);
        tick(0, 1, 0, 1);

        // flush at beat 4 with a simultaneous capture, then flush+capture while idle
        cap_vec = rand_vec(); tick(1, 1, 0, 0);
        repeat (4) tick(0, 1, 0, 0);
        cap_vec = rand_vec(); tick(1, 1, 1, 0);
        repeat (3) tick(0, 1, 0, 0);
        cap_vec = rand_vec(); tick(1, 0, 1, 0);
        tick(0, 1, 0, 0);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            cap_vec = rand_vec();
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0);
        end
        repeat (25) tick(0, 1, 0, 0);

        // asynchronous reset mid-vector, then a fresh capture
        cap_vec = rand_vec(); tick(1, 1, 0, 0);
        repeat (3) tick(0, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1 check_reset();
        model_reset();
        @(posedge clk); #1 reset_n = 1'b1;
        cap_vec = rand_vec(); tick(1, 1, 0, 0);
        repeat (12) tick(0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/layer_serializer.md
# layer_serializer

Parametrised parallel-to-stream converter between a neuron layer and the next consumer, such as the next layer or the max finder.
- Captures a full layer output vector of NEURONS_NUM words in one cycle.
- Replays it as a LANES-wide stream with valid/ready backpressure, a last-beat flag and a neuron index.
- Flags vectors dropped while busy (sticky overflow); supports synchronous flush.
- Replaces the fixed one-word-per-cycle, no-backpressure layer hold/shift logic in the network top.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per neuron output word
- NEURONS_NUM, 10, words per captured vector; must be a multiple of LANES
- LANES, 1, words per output beat; beats per vector BEATS = NEURONS_NUM/LANES
- IDX_W, $clog2(NEURONS_NUM) (minimum 1), width of o_index

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  reset; asynchronous, active-low
- i_flush  in  1  synchronous abort: discard active and pending vectors
- i_data_in_valid  in  1  capture strobe for i_data_in
- i_data_in  in  NEURONS_NUM*DATA_WIDTH  vector; word k = bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_data  out  LANES*DATA_WIDTH  current beat; lane 0 in low bits
- o_valid  out  1  beat valid
- i_ready  in  1  consumer accepts beat
- o_last  out  1  current beat is beat BEATS-1
- o_index  out  IDX_W  index of the word in lane 0
- o_busy  out  1  vector active or pending
- o_overflow  out  1  sticky: a capture was dropped
- i_clear_overflow  in  1  synchronous clear of o_overflow

## Operation
State machine:
- IDLE: no vector held.
- SEND: vector held, beats outstanding.

Transfer and beat sequence:
- A transfer occurs on a cycle with o_valid=1 and i_ready=1.
- Beat b carries words b*LANES .. b*LANES+LANES-1; o_index = b*LANES.
- Exactly BEATS beats are sent per vector; there is no trailing extra word.

Capture acceptance:
- Accepted in IDLE.
- Accepted in SEND on the cycle the last beat transfers (back-to-back).
- The accepted vector's beat 0 is presented the next cycle.

Dropped captures:
- Any other capture in SEND is discarded.
- o_overflow is set to 1 the next cycle.
- The active vector is unaffected.

Overflow clear:
- i_clear_overflow clears o_overflow.
- If a drop occurs in the same cycle as the clear, set wins.

Flush:
- i_flush returns the block to IDLE, deasserts o_valid and clears any pending vector.
- A capture in the same cycle as i_flush is discarded and does not set overflow.
- A beat transferred in the flush cycle counts as consumed.

Stall and busy:
- While o_valid=1 and i_ready=0, o_data, o_index and o_last hold stable.
- o_busy = (state==SEND) or pending vector held.

## Timing
Reset values (asynchronous, while reset_n=0):
- state=IDLE; o_valid=0, o_last=0, o_busy=0, o_overflow=0, o_index=0, o_data=0.
- Reset mid-vector abandons the vector with no further beats.

Latency and throughput:
- Capture at edge N; o_valid=1 with beat 0 after edge N.
- With i_ready held at 1, beats stream on consecutive cycles.
- Last transfer at cycle N+BEATS.
- o_valid falls after the last transfer unless a back-to-back or pending vector follows; in that case o_valid stays 1 with no bubble.

Flag timing:
- o_last and o_index are registered and aligned with o_data.
- o_overflow rises one cycle after the dropped strobe.

## Configuration
Macro: SERIALIZER_DOUBLE_BUFFER_EN.
- Defined: adds one NEURONS_NUM*DATA_WIDTH shadow register.
  - A capture during SEND goes to the shadow if it is empty, or if it drains in that cycle.
  - The shadow is loaded as the active vector on the last transfer.
  - Overflow is set only when the shadow is full and not draining.
- Undefined: no shadow register; the acceptance rules in Operation apply unchanged.

## Test plan
- Basic order (NEURONS_NUM=10, LANES=1, words 0..9 = 0x0001..0x000A, i_ready=1): exactly 10 beats, data 0x0001..0x000A, o_index 0..9, o_last only on 0x000A, o_valid low after.
- Backpressure (i_ready toggling 1,0,0,1…): each beat transferred exactly once; o_data/o_index stable across stalls; total 10 transfers.
- Lanes (LANES=2): 5 beats; beat 0 o_data = {0x0002,0x0001}, o_index=0; beat 4 o_index=8, o_last=1.
- Overflow (macro off): second capture at beat 3 dropped; o_overflow=1 one cycle later; first vector completes intact; i_clear_overflow returns flag to 0.
- Double buffer (macro on): second capture at beat 3 is sent immediately after beat 9 with no bubble; a third capture before then sets o_overflow.
- Flush/reset: i_flush at beat 4 → o_valid=0 next cycle, o_busy=0; reset_n low mid-vector → all outputs 0 asynchronously; a fresh capture afterwards restarts at o_index=0.
